// File: rtl/milano_pkg.sv
`default_nettype none
// ============================================================================
// Module      : milano_pkg
// Description : Shared types and constants for the milano execute stage:
//               ALU operation encoding, divider FSM states and the XLEN
//               constant.
// Revision    : 1.0 - initial release
// ============================================================================
package milano_pkg;

  localparam int unsigned XLEN = 32;

  // ALU operation select, as driven from the ID/EX register.
  // Encodings 14..31 are unused and execute as "illegal" (result 0).
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_SLL  = 5'd2,
    ALU_SLT  = 5'd3,
    ALU_SLTU = 5'd4,
    ALU_XOR  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_OR   = 5'd8,
    ALU_AND  = 5'd9,
    ALU_DIV  = 5'd10,
    ALU_DIVU = 5'd11,
    ALU_REM  = 5'd12,
    ALU_REMU = 5'd13
  } alu_opt_e;

  // Iterative divider states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  // True for the four operations handled by the multi-cycle divider.
  function automatic logic is_div_op(input alu_opt_e op);
    return (op == ALU_DIV) || (op == ALU_DIVU) || (op == ALU_REM) || (op == ALU_REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/milano_div.sv
`default_nettype none
// ============================================================================
// Module      : milano_div
// Description : Iterative restoring divider for DIV/DIVU/REM/REMU. Operands
//               are converted to magnitudes on start, 32 restoring steps run
//               one per cycle, and signs are re-applied in DONE. A zero
//               divisor skips the iteration and goes straight to DONE.
//               Used by ex_stage only when MILANO_DIV_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module milano_div
  import milano_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DIV_CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            start_i,
  input  logic            flush_i,
  input  alu_opt_e        op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] result_o
);

  div_state_e           state_q, state_d;
  logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0]      quo_q, quo_d;
  logic [XLEN-1:0]      rem_q, rem_d;
  logic [XLEN-1:0]      dvs_q, dvs_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic                 is_rem_q, is_rem_d;

  logic                 is_signed;
  logic                 a_neg, b_neg;
  logic [XLEN-1:0]      a_mag, b_mag;
  logic [XLEN:0]        shift_rem;
  logic [XLEN:0]        diff;
  logic                 step_ge;

  assign is_signed = (op_i == ALU_DIV) || (op_i == ALU_REM);
  assign a_neg     = is_signed & a_i[XLEN-1];
  assign b_neg     = is_signed & b_i[XLEN-1];
  assign a_mag     = a_neg ? (-a_i) : a_i;
  assign b_mag     = b_neg ? (-b_i) : b_i;

  // One restoring step: shift the next dividend bit into the partial
  // remainder and subtract the divisor if it fits. Bit XLEN of the
  // difference is the borrow, since the shifted remainder is < 2*divisor.
  assign shift_rem = {rem_q, quo_q[XLEN-1]};
  assign diff      = shift_rem - {1'b0, dvs_q};
  assign step_ge   = ~diff[XLEN];

  // Divider state, counter and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      quo_q    <= '0;
      rem_q    <= '0;
      dvs_q    <= '0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dvs_q    <= dvs_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      is_rem_q <= is_rem_d;
    end
  end

  // Next-state logic: start, iterate, finish; flush overrides everything.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dvs_d    = dvs_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    is_rem_d = is_rem_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          is_rem_d = (op_i == ALU_REM) || (op_i == ALU_REMU);
          if (b_i == '0) begin
            // Divide by zero: quotient all ones, remainder is the dividend.
            quo_d   = '1;
            rem_d   = a_i;
            q_neg_d = 1'b0;
            r_neg_d = 1'b0;
            state_d = DONE;
          end else begin
            quo_d   = a_mag;
            rem_d   = '0;
            dvs_d   = b_mag;
            q_neg_d = a_neg ^ b_neg;
            r_neg_d = a_neg;
            cnt_d   = DIV_CNT_W'(XLEN);
            state_d = DIV;
          end
        end
      end
      DIV: begin
        quo_d = {quo_q[XLEN-2:0], step_ge};
        rem_d = step_ge ? diff[XLEN-1:0] : shift_rem[XLEN-1:0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == DIV_CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end
  end

  // Sign correction is applied on the way out; the overflow case
  // (-2^31 / -1) falls out naturally as 0x8000_0000 with remainder 0.
  assign busy_o   = (state_q != IDLE);
  assign done_o   = (state_q == DONE);
  assign result_o = is_rem_q ? (r_neg_q ? (-rem_q) : rem_q)
                             : (q_neg_q ? (-quo_q) : quo_q);

endmodule
`default_nettype wire

// File: rtl/ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_stage
// Description : milano execute stage. Single-cycle ALU plus optional
//               iterative divider, with registered results towards EX/MEM.
//               stall_o holds upstream while a divide is in flight.
//               Build option: MILANO_DIV_EN - instantiate milano_div. When
//               undefined, divide ops execute as illegal (result 0, 1 cycle)
//               and stall_o is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_stage
  import milano_pkg::*;
#(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned DIV_CNT_W = 6
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic            flush_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wr_en_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  alu_opt_e        alu_operate_i,
  output logic            stall_o,
  output logic            valid_o,
  output logic [4:0]      rd_addr_o,
  output logic            rd_wr_en_o,
  output logic [XLEN-1:0] result_o
);

  // Only the 32-bit datapath is supported, and the counter must hold XLEN.
  if ((XLEN != 32) || ((1 << DIV_CNT_W) <= XLEN)) begin : g_bad_cfg
    $error("ex_stage: unsupported XLEN/DIV_CNT_W combination");
  end

  logic            accept;
  logic            is_div;
  logic            div_busy;
  logic            div_done;
  logic [XLEN-1:0] div_result;
  logic [4:0]      div_rd;
  logic            div_we;
  logic [4:0]      shamt;
  logic [XLEN-1:0] alu_res;

  logic            valid_q, valid_d;
  logic [4:0]      rd_addr_q, rd_addr_d;
  logic            rd_wr_en_q, rd_wr_en_d;
  logic [XLEN-1:0] result_q, result_d;

  assign stall_o = div_busy;
  assign accept  = valid_i & ~stall_o & ~flush_i;
  assign shamt   = rs2_data_i[4:0];

  // Single-cycle ALU; divide encodings and unused encodings yield 0.
  always_comb begin
    alu_res = '0;
    case (alu_operate_i)
      ALU_ADD:  alu_res = rs1_data_i + rs2_data_i;
      ALU_SUB:  alu_res = rs1_data_i - rs2_data_i;
      ALU_SLL:  alu_res = rs1_data_i << shamt;
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, ($signed(rs1_data_i) < $signed(rs2_data_i))};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, (rs1_data_i < rs2_data_i)};
      ALU_XOR:  alu_res = rs1_data_i ^ rs2_data_i;
      ALU_SRL:  alu_res = rs1_data_i >> shamt;
      ALU_SRA:  alu_res = $signed(rs1_data_i) >>> shamt;
      ALU_OR:   alu_res = rs1_data_i | rs2_data_i;
      ALU_AND:  alu_res = rs1_data_i & rs2_data_i;
      default:  alu_res = '0;
    endcase
  end

`ifdef MILANO_DIV_EN
  logic       div_start;
  logic [4:0] div_rd_q;
  logic       div_we_q;

  assign is_div    = is_div_op(alu_operate_i);
  assign div_start = accept & is_div;
  assign div_rd    = div_rd_q;
  assign div_we    = div_we_q;

  milano_div #(
    .XLEN      (XLEN),
    .DIV_CNT_W (DIV_CNT_W)
  ) u_div (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .start_i  (div_start),
    .flush_i  (flush_i),
    .op_i     (alu_operate_i),
    .a_i      (rs1_data_i),
    .b_i      (rs2_data_i),
    .busy_o   (div_busy),
    .done_o   (div_done),
    .result_o (div_result)
  );

  // Hold the divide's destination fields while upstream moves on.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_rd_q <= '0;
      div_we_q <= 1'b0;
    end else if (div_start) begin
      div_rd_q <= rd_addr_i;
      div_we_q <= rd_wr_en_i;
    end
  end
`else
  assign is_div     = 1'b0;
  assign div_busy   = 1'b0;
  assign div_done   = 1'b0;
  assign div_result = '0;
  assign div_rd     = '0;
  assign div_we     = 1'b0;
`endif

  // Result mux: divide completion (unless flushed) or an accepted ALU op.
  always_comb begin
    valid_d    = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_wr_en_d = rd_wr_en_q;
    result_d   = result_q;
    if (div_done && !flush_i) begin
      valid_d    = 1'b1;
      rd_addr_d  = div_rd;
      rd_wr_en_d = div_we;
      result_d   = div_result;
    end else if (accept && !is_div) begin
      valid_d    = 1'b1;
      rd_addr_d  = rd_addr_i;
      rd_wr_en_d = rd_wr_en_i;
      result_d   = alu_res;
    end
  end

  // EX/MEM output registers; data holds when no result is produced.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q    <= 1'b0;
      rd_addr_q  <= '0;
      rd_wr_en_q <= 1'b0;
      result_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      rd_addr_q  <= rd_addr_d;
      rd_wr_en_q <= rd_wr_en_d;
      result_q   <= result_d;
    end
  end

  assign valid_o    = valid_q;
  assign rd_addr_o  = rd_addr_q;
  assign rd_wr_en_o = rd_wr_en_q & valid_q;
  assign result_o   = result_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_stage
// Description : Self-checking bench for ex_stage: directed vector table,
//               hand-written flush/reset/back-to-back sequences and random
//               operations checked against an arithmetic reference model.
//               Divide expectations follow MILANO_DIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_stage;
  import milano_pkg::*;

`ifdef MILANO_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        valid_i;
  logic        flush_i;
  logic [4:0]  rd_addr_i;
  logic        rd_wr_en_i;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  alu_opt_e    alu_op;
  logic        stall_o;
  logic        valid_o;
  logic [4:0]  rd_addr_o;
  logic        rd_wr_en_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;

  ex_stage #(.XLEN(32), .DIV_CNT_W(6)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .valid_i       (valid_i),
    .flush_i       (flush_i),
    .rd_addr_i     (rd_addr_i),
    .rd_wr_en_i    (rd_wr_en_i),
    .rs1_data_i    (rs1_data_i),
    .rs2_data_i    (rs2_data_i),
    .alu_operate_i (alu_op),
    .stall_o       (stall_o),
    .valid_o       (valid_o),
    .rd_addr_o     (rd_addr_o),
    .rd_wr_en_o    (rd_wr_en_o),
    .result_o      (result_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        we;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Reference model from the architectural definition of each operation.
  function automatic void ref_model(input logic [4:0] op, input logic [31:0] a,
                                    input logic [31:0] b, output logic [31:0] res,
                                    output int lat);
    logic [31:0] ones;
    int unsigned sh;
    logic        ovf;
    ones = 32'hFFFF_FFFF;
    sh   = b[4:0];
    ovf  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    res  = 32'h0;
    lat  = 1;
    case (alu_opt_e'(op))
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_SLL:  res = a << sh;
      ALU_SLT:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU: res = (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:  res = a ^ b;
      ALU_SRL:  res = a >> sh;
      ALU_SRA:  res = (a >> sh) | (a[31] ? ~(ones >> sh) : 32'h0);
      ALU_OR:   res = a | b;
      ALU_AND:  res = a & b;
      ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU: begin
        if (DIV_EN) begin
          lat = (b == 32'h0) ? 2 : 34;
          case (alu_opt_e'(op))
            ALU_DIV:  res = (b == 0) ? ones : (ovf ? a : $signed(a) / $signed(b));
            ALU_DIVU: res = (b == 0) ? ones : a / b;
            ALU_REM:  res = (b == 0) ? a : (ovf ? 32'h0 : $signed(a) % $signed(b));
            default:  res = (b == 0) ? a : a % b;
          endcase
        end
      end
      default:  res = 32'h0;
    endcase
  endfunction

  // Issue one instruction, wait (bounded) for its result and check it.
  task automatic run_op(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd, input logic we,
                        input logic [31:0] exp, input int exp_lat);
    int lat;
    int stalls;
    bit seen;
    valid_i    = 1'b1;
    alu_op     = alu_opt_e'(op);
    rs1_data_i = a;
    rs2_data_i = b;
    rd_addr_i  = rd;
    rd_wr_en_i = we;
    @(posedge clk); #1;
    valid_i    = 1'b0;
    rs1_data_i = $urandom;
    rs2_data_i = $urandom;
    rd_addr_i  = 5'($urandom);
    rd_wr_en_i = ~we;
    lat    = 1;
    stalls = 0;
    seen   = 1'b0;
    while (lat <= 60) begin
      if (valid_o) begin
        seen = 1'b1;
        break;
      end
      if (stall_o) stalls++;
      @(posedge clk); #1;
      lat++;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no valid_o within 60 cycles, expected latency %0d", name, exp_lat);
    end else begin
      check({name, " latency"}, lat, exp_lat);
      check({name, " stall cycles"}, stalls, exp_lat - 1);
      check({name, " result"}, result_o, exp);
      check({name, " rd_addr"}, rd_addr_o, rd);
      check({name, " rd_wr_en"}, rd_wr_en_o, we);
      @(posedge clk); #1;
      check({name, " valid drop"}, valid_o, 0);
      check({name, " we drop"}, rd_wr_en_o, 0);
      check({name, " result hold"}, result_o, exp);
    end
  endtask

  // Start a DIVU, then at cycle 10 either flush or pulse reset.
  task automatic abort_div(input string name, input bit use_reset);
    int stall_hi;
    int valids;
    valid_i    = 1'b1;
    alu_op     = ALU_DIVU;
    rs1_data_i = 32'd1000;
    rs2_data_i = 32'd3;
    rd_addr_i  = 5'd4;
    rd_wr_en_i = 1'b1;
    @(posedge clk); #1;
    // Upstream keeps presenting an ADD; it must be ignored while stalled.
    alu_op     = ALU_ADD;
    rs1_data_i = 32'd50;
    rs2_data_i = 32'd50;
    stall_hi   = 0;
    valids     = 0;
    for (int c = 1; c < 9; c++) begin
      if (stall_o) stall_hi++;
      if (valid_o) valids++;
      @(posedge clk); #1;
    end
    check({name, " stall while busy"}, stall_hi, 8);
    valid_i = 1'b0;
    if (use_reset) begin
      rst_n = 1'b0;
      #1;
      check({name, " reset stall"}, stall_o, 0);
      check({name, " reset valid"}, valid_o, 0);
      check({name, " reset result"}, result_o, 0);
      check({name, " reset rd"}, rd_addr_o, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
    end else begin
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      check({name, " stall low"}, stall_o, 0);
    end
    for (int c = 0; c < 40; c++) begin
      if (valid_o) valids++;
      @(posedge clk); #1;
    end
    check({name, " no valid"}, valids, 0);
    run_op({name, " add"}, 5'(ALU_ADD), 32'd1, 32'd1, 5'd3, 1'b1, 32'd2, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] r_exp;
    int          r_lat;
    logic [4:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;

    rst_n      = 1'b0;
    valid_i    = 1'b0;
    flush_i    = 1'b0;
    rd_addr_i  = '0;
    rd_wr_en_i = 1'b0;
    rs1_data_i = '0;
    rs2_data_i = '0;
    alu_op     = ALU_ADD;
    repeat (3) @(posedge clk);
    #1;
    check("reset valid_o", valid_o, 0);
    check("reset stall_o", stall_o, 0);
    check("reset rd_addr_o", rd_addr_o, 0);
    check("reset rd_wr_en_o", rd_wr_en_o, 0);
    check("reset result_o", result_o, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors: {op, a, b, rd, we, expected, latency}.
    vecs.push_back('{5'(ALU_ADD),  32'h7FFF_FFFF, 32'h1,         5'd5,  1'b1, 32'h8000_0000, 1});
    vecs.push_back('{5'(ALU_SUB),  32'h0,         32'h1,         5'd1,  1'b1, 32'hFFFF_FFFF, 1});
    vecs.push_back('{5'(ALU_SLL),  32'h1,         32'h3F,        5'd2,  1'b1, 32'h8000_0000, 1});
    vecs.push_back('{5'(ALU_SLT),  32'hFFFF_FFFF, 32'h1,         5'd3,  1'b1, 32'h1,         1});
    vecs.push_back('{5'(ALU_SLTU), 32'hFFFF_FFFF, 32'h1,         5'd4,  1'b1, 32'h0,         1});
    vecs.push_back('{5'(ALU_XOR),  32'hF0F0_F0F0, 32'hFF00_FF00, 5'd6,  1'b1, 32'h0FF0_0FF0, 1});
    vecs.push_back('{5'(ALU_SRL),  32'h8000_0000, 32'h4,         5'd7,  1'b1, 32'h0800_0000, 1});
    vecs.push_back('{5'(ALU_SRA),  32'h8000_0000, 32'h21,        5'd8,  1'b1, 32'hC000_0000, 1});
    vecs.push_back('{5'(ALU_OR),   32'h1234_0000, 32'h0000_5678, 5'd9,  1'b1, 32'h1234_5678, 1});
    vecs.push_back('{5'(ALU_AND),  32'hFFFF_0000, 32'h1234_5678, 5'd10, 1'b1, 32'h1234_0000, 1});
    vecs.push_back('{5'd20,        32'h1,         32'h2,         5'd11, 1'b1, 32'h0,         1});
    vecs.push_back('{5'(ALU_ADD),  32'h3,         32'h4,         5'd0,  1'b1, 32'h7,         1});
    vecs.push_back('{5'(ALU_ADD),  32'h5,         32'h5,         5'd12, 1'b0, 32'hA,         1});
    vecs.push_back('{5'(ALU_DIV),  32'hFFFF_FFF9, 32'h2,         5'd13, 1'b1, DIV_EN ? 32'hFFFF_FFFD : 32'h0, DIV_EN ? 34 : 1});
    vecs.push_back('{5'(ALU_REM),  32'hFFFF_FFF9, 32'h2,         5'd14, 1'b1, DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? 34 : 1});
    vecs.push_back('{5'(ALU_DIVU), 32'h1234,      32'h0,         5'd15, 1'b1, DIV_EN ? 32'hFFFF_FFFF : 32'h0, DIV_EN ? 2 : 1});
    vecs.push_back('{5'(ALU_REMU), 32'h1234,      32'h0,         5'd16, 1'b1, DIV_EN ? 32'h1234 : 32'h0,      DIV_EN ? 2 : 1});
    vecs.push_back('{5'(ALU_DIV),  32'h8000_0000, 32'hFFFF_FFFF, 5'd17, 1'b1, DIV_EN ? 32'h8000_0000 : 32'h0, DIV_EN ? 34 : 1});
    vecs.push_back('{5'(ALU_REM),  32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 1'b1, 32'h0,                         DIV_EN ? 34 : 1});
    vecs.push_back('{5'(ALU_DIVU), 32'd100,       32'd7,         5'd19, 1'b1, DIV_EN ? 32'd14 : 32'h0,       DIV_EN ? 34 : 1});
    vecs.push_back('{5'(ALU_REMU), 32'd100,       32'd7,         5'd20, 1'b0, DIV_EN ? 32'd2 : 32'h0,        DIV_EN ? 34 : 1});
    vecs.push_back('{5'(ALU_REM),  32'hFFFF_FFFB, 32'h0,         5'd21, 1'b1, DIV_EN ? 32'hFFFF_FFFB : 32'h0, DIV_EN ? 2 : 1});

    foreach (vecs[i]) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
             vecs[i].rd, vecs[i].we, vecs[i].exp, vecs[i].lat);
    end

    // Back-to-back: SRA then SLTU on consecutive cycles.
    valid_i = 1'b1; alu_op = ALU_SRA; rs1_data_i = 32'h8000_0000; rs2_data_i = 32'h21;
    rd_addr_i = 5'd22; rd_wr_en_i = 1'b1;
    @(posedge clk); #1;
    alu_op = ALU_SLTU; rs1_data_i = 32'h1; rs2_data_i = 32'hFFFF_FFFF; rd_addr_i = 5'd23;
    check("b2b sra valid", valid_o, 1);
    check("b2b sra result", result_o, 32'hC000_0000);
    @(posedge clk); #1;
    valid_i = 1'b0;
    check("b2b sltu valid", valid_o, 1);
    check("b2b sltu result", result_o, 32'h1);
    check("b2b sltu rd", rd_addr_o, 5'd23);
    @(posedge clk); #1;
    check("b2b idle", valid_o, 0);

    // Flush in IDLE blocks the accept.
    valid_i = 1'b1; flush_i = 1'b1; alu_op = ALU_ADD; rs1_data_i = 32'd9; rs2_data_i = 32'd9;
    @(posedge clk); #1;
    valid_i = 1'b0; flush_i = 1'b0;
    check("idle flush valid", valid_o, 0);
    check("idle flush result", result_o, 32'h1);

`ifdef MILANO_DIV_EN
    abort_div("flush div", 1'b0);
    abort_div("reset div", 1'b1);
`endif

    // Random operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      r_op = 5'($urandom_range(0, 15));
      if (r_op > 5'd13) r_op = 5'($urandom_range(14, 31));
      r_a = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      case ($urandom_range(0, 3))
        0:       r_b = 32'h0;
        1:       r_b = $urandom_range(1, 20);
        default: r_b = $urandom;
      endcase
      ref_model(r_op, r_a, r_b, r_exp, r_lat);
      run_op($sformatf("rand%0d op%0d", i, r_op), r_op, r_a, r_b,
             5'($urandom), 1'($urandom), r_exp, r_lat);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
